dbus_arb: RTL



---
 rtl/rei_pkg.sv | 11 +
 rtl/dbus_arb_pick.sv | 24 ++
 rtl/dbus_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/rei_pkg.sv
// Shared data-side bus constants and the dbus_arb state encoding.
package rei_pkg;
    localparam int XLEN   = 64;
    localparam int XBYTES = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RD_WAIT = 2'd2
    } dbus_arb_state_e;
endpackage

// File: rtl/dbus_arb_pick.sv
// Two-way grant picker for dbus_arb: fixed priority (requester 0 wins) or,
// with DBUS_ARB_RR_EN defined, round-robin where the non-pointer requester wins a tie.
module dbus_arb_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
`ifdef DBUS_ARB_RR_EN
    always_comb begin
        gnt = req;
        // ptr holds the last granted requester, so the other one takes the tie
        if (req == 2'b11) gnt = ptr ? 2'b01 : 2'b10;
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        gnt = 2'b00;
        if (req[0])      gnt = 2'b01;
        else if (req[1]) gnt = 2'b10;
    end
`endif
endmodule

// File: rtl/dbus_arb.sv
// Two-requester data-bus arbiter: zero-cycle issue, grant held until accept,
// one outstanding read. Optional round-robin via DBUS_ARB_RR_EN.
module dbus_arb
    import rei_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_arvalid_i,
    input  logic              m0_wvalid_i,
    input  logic [XLEN-1:0]   m0_addr_i,
    input  logic [XLEN-1:0]   m0_wdata_i,
    input  logic [XBYTES-1:0] m0_wstrb_i,
    output logic              m0_ready_o,
    output logic              m0_rvalid_o,
    output logic [XLEN-1:0]   m0_rdata_o,
    input  logic              m1_arvalid_i,
    input  logic              m1_wvalid_i,
    input  logic [XLEN-1:0]   m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    input  logic [XBYTES-1:0] m1_wstrb_i,
    output logic              m1_ready_o,
    output logic              m1_rvalid_o,
    output logic [XLEN-1:0]   m1_rdata_o,
    output logic              s_arvalid_o,
    output logic              s_wvalid_o,
    output logic [XLEN-1:0]   s_addr_o,
    output logic [XLEN-1:0]   s_wdata_o,
    output logic [XBYTES-1:0] s_wstrb_o,
    input  logic              s_ready_i,
    input  logic              s_rvalid_i,
    input  logic [XLEN-1:0]   s_rdata_i,
    output logic              err_o
);
    dbus_arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       err_q, err_set;
    logic       ptr;
    logic [1:0] req, gnt;
    logic       sel, active, sel_wr, accept, rd_done;

    assign req = {m1_arvalid_i | m1_wvalid_i, m0_arvalid_i | m0_wvalid_i};

    dbus_arb_pick u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        sel     = owner_q;
        active  = 1'b0;
        case (state_q)
            IDLE: begin
                sel    = gnt[1];
                active = |req;
            end
            HOLD:    active = 1'b1;
            RD_WAIT: if (s_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rst_i) active = 1'b0;
        // arvalid+wvalid together is illegal; the write wins
        sel_wr = sel ? m1_wvalid_i : m0_wvalid_i;
        accept = active & s_ready_i;
        if (active) begin
            owner_d = sel;
            if (!s_ready_i)  state_d = HOLD;
            else if (sel_wr) state_d = IDLE;
            else             state_d = RD_WAIT;
        end
    end

    assign s_wvalid_o  = active & sel_wr;
    assign s_arvalid_o = active & ~sel_wr;
    assign s_addr_o    = !active ? '0 : (sel ? m1_addr_i  : m0_addr_i);
    assign s_wdata_o   = !active ? '0 : (sel ? m1_wdata_i : m0_wdata_i);
    assign s_wstrb_o   = !active ? '0 : (sel ? m1_wstrb_i : m0_wstrb_i);
    assign m0_ready_o  = accept & ~sel;
    assign m1_ready_o  = accept & sel;

    assign rd_done     = (state_q == RD_WAIT) & s_rvalid_i & ~rst_i;
    assign m0_rvalid_o = rd_done & ~owner_q;
    assign m1_rvalid_o = rd_done & owner_q;
    assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

    assign err_set = (s_rvalid_i & (state_q != RD_WAIT))
                   | (m0_arvalid_i & m0_wvalid_i)
                   | (m1_arvalid_i & m1_wvalid_i);
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (err_set) err_q <= 1'b1;
        end
    end

`ifdef DBUS_ARB_RR_EN
    logic ptr_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)       ptr_q <= 1'b0;
        else if (accept) ptr_q <= sel;
    end
    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif
endmodule
